// File: rtl/cmem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : cmem                                                          |
// | Description: 64 x 16 coefficient memory for the FIR MAC datapath. Single   |
// |              port with a shared read/write address, registered read data,  |
// |              write-first read-during-write, and asynchronous clear of the   |
// |              whole array. Optional even-parity protection per entry is     |
// |              enabled by defining CMEM_PARITY_EN (adds port parity_err).    |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module cmem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6    // 2**ADDR_W must equal DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
`ifdef CMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  // Flop-based storage: the entire array has to clear on asynchronous reset,
  // which a RAM macro cannot do.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;

  // Storage update: clear everything on reset, otherwise write the addressed entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_en) begin
      mem_q[addr] <= data_in;
    end
  end

  // Write-first read mux: a write on this edge is returned directly.
  always_comb begin
    data_out_d = mem_q[addr];
    if (w_en) begin
      data_out_d = data_in;
    end
  end

  // Registered read port, 1-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

`ifdef CMEM_PARITY_EN
  // Even parity: the stored bit makes the total count of ones (data + bit) even,
  // so an all-zero entry with a zero parity bit is consistent after reset.
  logic par_q [DEPTH];
  logic parity_err_q;
  logic parity_err_d;

  // Parity storage tracks the data array write-for-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
    end else if (w_en) begin
      par_q[addr] <= ^data_in;
    end
  end

  // Parity check of the word being read; write-first reads are fresh and never flag.
  always_comb begin
    parity_err_d = (^mem_q[addr]) != par_q[addr];
    if (w_en) begin
      parity_err_d = 1'b0;
    end
  end

  // Registered error flag, aligned with data_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_cmem                                                       |
// | Description: Directed self-checking bench for cmem. Parity scenario is     |
// |              included when CMEM_PARITY_EN is defined.                      |
// | Revision   : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_cmem;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic              w_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
`ifdef CMEM_PARITY_EN
  logic              parity_err;
`endif

  int n_checks;
  int n_fail;

  cmem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .w_en    (w_en),
    .data_in (data_in),
    .data_out(data_out)
`ifdef CMEM_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one write at the next falling edge, clock it in, settle 1 ns past the edge.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    addr    = a;
    data_in = d;
    w_en    = 1'b1;
    @(posedge clk);
    #1;
    w_en    = 1'b0;
  endtask

  // Present a read address at the falling edge, sample 1 ns after the rising edge.
  task automatic do_read(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    addr = a;
    w_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [ADDR_W-1:0] ra [3];
    ra[0] = 6'd0; ra[1] = 6'd31; ra[2] = 6'd63;
    // Make data_out non-zero first so the clear is observable.
    do_write(6'd0, 16'h5555);
    n_checks++;
    if (data_out !== 16'h5555) begin
      n_fail++;
      $display("FAIL reset_pre: data_out=%h expected=%h", data_out, 16'h5555);
    end
    // Asynchronous pulse between edges.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: data_out=%h expected=%h", data_out, 16'h0000);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_read(ra[i]);
      n_checks++;
      if (data_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_read a=%0d: data_out=%h expected=%h", ra[i], data_out, 16'h0000);
      end
    end
  endtask

  task automatic test_sweep();
    // Back-to-back writes, one per cycle; the last is clocked before w_en drops.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      addr    = 6'(i);
      data_in = 16'h1000 + 16'(i);
      w_en    = 1'b1;
    end
    @(negedge clk);
    w_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(6'(i));
      n_checks++;
      if (data_out !== 16'h1000 + 16'(i)) begin
        n_fail++;
        $display("FAIL sweep a=%0d: data_out=%h expected=%h", i, data_out, 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_latency();
    do_write(6'd5, 16'hBEEF);
    do_write(6'd6, 16'h1234);
    do_read(6'd5);
    n_checks++;
    if (data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL latency_a5: data_out=%h expected=%h", data_out, 16'hBEEF);
    end
    // Address change and a write pulse that ends before the edge must not take effect.
    @(negedge clk);
    addr    = 6'd6;
    data_in = 16'hDEAD;
    w_en    = 1'b1;
    #1 w_en = 1'b0;
    #1;
    n_checks++;
    if (data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL latency_hold: data_out=%h expected=%h", data_out, 16'hBEEF);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL latency_a6: data_out=%h expected=%h", data_out, 16'h1234);
    end
  endtask

  task automatic test_read_during_write();
    do_write(6'd10, 16'h1111);
    do_read(6'd10);
    n_checks++;
    if (data_out !== 16'h1111) begin
      n_fail++;
      $display("FAIL rdw_before: data_out=%h expected=%h", data_out, 16'h1111);
    end
    do_write(6'd10, 16'h2222);
    n_checks++;
    if (data_out !== 16'h2222) begin
      n_fail++;
      $display("FAIL rdw_same_edge: data_out=%h expected=%h", data_out, 16'h2222);
    end
    do_read(6'd11);
    do_read(6'd10);
    n_checks++;
    if (data_out !== 16'h2222) begin
      n_fail++;
      $display("FAIL rdw_after: data_out=%h expected=%h", data_out, 16'h2222);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [ADDR_W-1:0] ra [4];
    ra[0] = 6'd3; ra[1] = 6'd5; ra[2] = 6'd10; ra[3] = 6'd63;
    // Entries are populated by the earlier tests; confirm addr 3 is non-zero.
    do_read(6'd3);
    n_checks++;
    if (data_out !== 16'h1003) begin
      n_fail++;
      $display("FAIL midrst_pre: data_out=%h expected=%h", data_out, 16'h1003);
    end
    // Write to addr 3 set up, reset asserted across the edge that would clock it.
    @(negedge clk);
    addr    = 6'd3;
    data_in = 16'hAAAA;
    w_en    = 1'b1;
    #3 rst  = 1'b1;
    #1;
    n_checks++;
    if (data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrst_async: data_out=%h expected=%h", data_out, 16'h0000);
    end
    @(posedge clk);
    #2;
    w_en = 1'b0;
    rst  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_read(ra[i]);
      n_checks++;
      if (data_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL midrst_read a=%0d: data_out=%h expected=%h", ra[i], data_out, 16'h0000);
      end
    end
  endtask

`ifdef CMEM_PARITY_EN
  task automatic test_parity();
    do_write(6'd7, 16'h0001);
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_wf: parity_err=%b expected=%b", parity_err, 1'b0);
    end
    do_read(6'd7);
    n_checks++;
    if (data_out !== 16'h0001 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clean: data_out=%h parity_err=%b expected=0001/0", data_out, parity_err);
    end
    // Flip one stored data bit behind the design's back.
    force dut.mem_q[7] = 16'h0003;
    do_read(6'd7);
    n_checks++;
    if (parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_flip: parity_err=%b expected=%b", parity_err, 1'b1);
    end
    release dut.mem_q[7];
    do_write(6'd7, 16'h0001);
    do_read(6'd7);
    n_checks++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_recover: parity_err=%b expected=%b", parity_err, 1'b0);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    addr     = '0;
    w_en     = 1'b0;
    data_in  = '0;
    test_reset();
    test_sweep();
    test_latency();
    test_read_during_write();
    test_reset_mid_op();
`ifdef CMEM_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmem.md
Name: cmem

Overview:
- 64-entry × 16-bit coefficient memory for the 64-tap, 16-bit FIR filter.
- Single port, shared read/write address.
- Holds the tap coefficients that the FIR MAC datapath reads one per cycle.
- Loaded by the host/config side through the same port.

Parameters:
- DATA_W, 16, coefficient word width in bits
- DEPTH, 64, number of coefficient entries (taps)
- ADDR_W, 6, address width; must satisfy 2**ADDR_W == DEPTH

Ports:
- clk  input  1  rising-edge clock for all writes and reads
- rst  input  1  asynchronous, active-high reset
- addr  input  ADDR_W  word address, used for both read and write
- w_en  input  1  write enable; sampled at the rising edge of clk
- data_in  input  DATA_W  write data
- data_out  output  DATA_W  registered read data

Behaviour:
- Reset (rst=1, asynchronous, no clock needed):
  - all DEPTH entries clear to 0
  - data_out clears to 0
  - held at 0 while rst stays high; writes are ignored during reset
- Write: on a rising clk edge with w_en=1 and rst=0, mem[addr] <= data_in. Only that entry changes.
- Read:
  - data_out is registered, with 1-cycle latency.
  - On every rising edge with rst=0, data_out <= mem[addr]. This happens whether w_en is 0 or 1.
  - Value is valid from just after the edge and holds until the next edge.
- Read-during-write (same edge, w_en=1): write-first. data_out <= data_in for that edge, so data_out equals the value just stored.
- Unwritten entries read 0 after reset.
- Address is always in range (full 6-bit decode), so there are no out-of-range cases.
- Changes to addr, w_en or data_in between edges have no effect.
- Reset mid-operation: asserting rst between or on edges clears everything immediately. A write on the edge coincident with rst is lost.
- Implementation: flop-based array, required because the whole array must clear on asynchronous reset. No latches.

Optional Feature:
- Macro: CMEM_PARITY_EN
- With CMEM_PARITY_EN defined:
  - each entry stores one extra even-parity bit computed from data_in at write time
  - new output port parity_err (1 bit, registered) goes to 1 on the edge where the read word's stored parity mismatches its data, and 0 otherwise
  - write-first reads use freshly computed parity, so parity_err=0 on those reads
  - reset clears all parity bits to 0 (consistent with zero data) and clears parity_err to 0
- Without the macro: no parity storage, no parity_err port; behaviour exactly as above.

Test Plan:
- Reset: pulse rst=1 mid-cycle with no clock edge → data_out=0x0000 immediately; then read addr 0, 31, 63 → 0x0000 each.
- Full write/read sweep:
  - write addr i with 0x1000+i for i=0..63, one per cycle
  - w_en=0, then for each i set addr=i, wait one edge, check data_out
  - expect data_out=0x1000+i for all 64 entries, including addr 63 (the last write must be clocked before w_en drops)
- Read latency: write 0xBEEF to addr 5, 0x1234 to addr 6; set addr=5 then addr=6 on consecutive cycles → data_out=0xBEEF one edge after addr=5, 0x1234 one edge after addr=6.
- Read-during-write: addr=10 holds 0x1111; w_en=1, data_in=0x2222, addr=10 → after the edge data_out=0x2222; a subsequent read of addr 10 also gives 0x2222.
- Reset mid-operation: fill entries, assert rst asynchronously while w_en=1 writes 0xAAAA to addr 3 → no write occurs; after release all reads, including addr 3, return 0x0000.
- Parity (CMEM_PARITY_EN): write 0x0001 to addr 7, read it back → data_out=0x0001, parity_err=0; force a stored data bit flip in simulation and read again → parity_err=1 on that read.
